// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a one-byte holding register so consecutive bytes
// leave back-to-back; every output is driven from a flop.
module uart_tx_serializer #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TxEn,
   input  logic [7:0] TxData,
   output logic       TxSerial,
   output logic       TxBusy,
   output logic       TxDone,
   output logic       TxOverrun
);

   localparam int unsigned   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          serial_q, serial_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ovr_q, ovr_d;
   logic          bit_end;
   logic          stop_end;

   assign bit_end  = (cnt_q == CNT_MAX);
   assign stop_end = (state_q == STOP) && bit_end;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      done_d      = 1'b0;
      ovr_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (TxEn) begin
               shift_d = TxData;
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               done_d = 1'b1;
               cnt_d  = '0;
               // A held byte wins; a coincident strobe refills the slot it frees.
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  state_d     = START;
                  hold_full_d = TxEn;
                  if (TxEn) begin
                     hold_d = TxData;
                  end
               end else if (TxEn) begin
                  shift_d = TxData;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && !stop_end && TxEn) begin
         if (!hold_full_q) begin
            hold_d      = TxData;
            hold_full_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // Line level and busy follow the state being entered so they stay registered.
   always_comb begin
      serial_d = 1'b1;
      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
         default: serial_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         serial_q    <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         serial_q    <= serial_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
      end
   end

   assign TxSerial  = serial_q;
   assign TxBusy    = busy_q;
   assign TxDone    = done_q;
   assign TxOverrun = ovr_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level timeline model predicts every
// output cycle by cycle for directed and random strobe schedules.
module tb_uart_tx_serializer;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
   localparam int MAXC  = 600;

   logic       clk = 1'b0;
   logic       reset;
   logic       TxEn;
   logic [7:0] TxData;
   logic       TxSerial;
   logic       TxBusy;
   logic       TxDone;
   logic       TxOverrun;

   int n_checks = 0;
   int n_fail   = 0;

   int         ev_cyc [0:7];
   logic [7:0] ev_dat [0:7];
   int         n_ev;

   logic exp_ser  [0:MAXC];
   logic exp_busy [0:MAXC];
   logic exp_done [0:MAXC];
   logic exp_ovr  [0:MAXC];

   uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .reset    (reset),
      .TxEn     (TxEn),
      .TxData   (TxData),
      .TxSerial (TxSerial),
      .TxBusy   (TxBusy),
      .TxDone   (TxDone),
      .TxOverrun(TxOverrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int c, input logic obs, input logic expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s cycle %0d: got %b expected %b", tag, c, obs, expv);
      end
   endtask

   // Frames are placed on a timeline: a strobe at edge e starts a frame at
   // cycle e+1 when idle, chains at L+1 when it lands on the last stop cycle L,
   // parks in the single holding slot mid-frame, or overruns when the slot is full.
   task automatic build_model(input int ncyc, input int rst_edge);
      int         fs[$];
      logic [7:0] fb[$];
      int         last;
      bit         held;
      logic [7:0] hb;
      last = -1000;
      held = 0;
      hb   = '0;
      for (int c = 0; c <= MAXC; c++) begin
         exp_ser[c] = 1'b1; exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_ovr[c] = 1'b0;
      end
      for (int k = 0; k < n_ev; k++) begin
         int e;
         e = ev_cyc[k];
         if (held && last < e) begin
            fs.push_back(last + 1); fb.push_back(hb);
            last = last + FRAME; held = 0;
         end
         if (e > last) begin
            fs.push_back(e + 1); fb.push_back(ev_dat[k]);
            last = e + FRAME;
         end else if (e == last) begin
            if (held) begin
               fs.push_back(last + 1); fb.push_back(hb);
               hb = ev_dat[k];
            end else begin
               fs.push_back(last + 1); fb.push_back(ev_dat[k]);
            end
            last = last + FRAME;
         end else if (!held) begin
            held = 1; hb = ev_dat[k];
         end else if (e + 1 <= MAXC) begin
            exp_ovr[e + 1] = 1'b1;
         end
      end
      if (held) begin
         fs.push_back(last + 1); fb.push_back(hb);
      end
      for (int f = 0; f < fs.size(); f++) begin
         logic [7:0] b;
         b = fb[f];
         for (int j = 0; j < FRAME; j++) begin
            int c, slot;
            c    = fs[f] + j;
            slot = j / CPB;
            if (c <= MAXC) begin
               exp_busy[c] = 1'b1;
               exp_ser[c]  = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot - 1];
            end
         end
         if (fs[f] + FRAME <= MAXC) exp_done[fs[f] + FRAME] = 1'b1;
      end
      if (rst_edge >= 0) begin
         for (int c = rst_edge + 1; c <= MAXC; c++) begin
            exp_ser[c] = 1'b1; exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_ovr[c] = 1'b0;
         end
      end
   endtask

   // Cycle c+1 is the interval after edge c; strobes listed for edge c are driven before it.
   task automatic run_scenario(input string name, input int ncyc, input int rst_edge);
      build_model(ncyc, rst_edge);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         TxEn   = 1'b0;
         TxData = 8'($urandom);
         reset  = (c == rst_edge) ? 1'b0 : 1'b1;
         for (int k = 0; k < n_ev; k++) begin
            if (ev_cyc[k] == c) begin
               TxEn = 1'b1; TxData = ev_dat[k];
            end
         end
         @(posedge clk);
         #1;
         check({name, ".TxSerial"},  c + 1, TxSerial,  exp_ser[c + 1]);
         check({name, ".TxBusy"},    c + 1, TxBusy,    exp_busy[c + 1]);
         check({name, ".TxDone"},    c + 1, TxDone,    exp_done[c + 1]);
         check({name, ".TxOverrun"}, c + 1, TxOverrun, exp_ovr[c + 1]);
      end
      @(negedge clk);
      TxEn  = 1'b0;
      reset = 1'b1;
   endtask

   initial begin
      int t;
      reset  = 1'b0;
      TxEn   = 1'b0;
      TxData = 8'h00;

      // Reset held for three edges, then twenty idle cycles.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst.TxSerial",  i, TxSerial,  1'b1);
         check("rst.TxBusy",    i, TxBusy,    1'b0);
         check("rst.TxDone",    i, TxDone,    1'b0);
         check("rst.TxOverrun", i, TxOverrun, 1'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      n_ev  = 0;
      run_scenario("idle", 20, -1);

      n_ev = 1; ev_cyc[0] = 0; ev_dat[0] = 8'hA5;
      run_scenario("single", 50, -1);

      n_ev = 2; ev_cyc[0] = 0; ev_dat[0] = 8'h3C; ev_cyc[1] = 10; ev_dat[1] = 8'hC3;
      run_scenario("b2b", 90, -1);

      n_ev = 3;
      ev_cyc[0] = 0;  ev_dat[0] = 8'h11;
      ev_cyc[1] = 6;  ev_dat[1] = 8'h22;
      ev_cyc[2] = 12; ev_dat[2] = 8'h33;
      run_scenario("overrun", 90, -1);

      // Reset lands in data bit 3 of the 0xFF frame, with 0x55 held.
      n_ev = 2; ev_cyc[0] = 0; ev_dat[0] = 8'hFF; ev_cyc[1] = 5; ev_dat[1] = 8'h55;
      run_scenario("midreset", 100, 18);
      n_ev = 1; ev_cyc[0] = 0; ev_dat[0] = 8'h00;
      run_scenario("after_rst", 50, -1);

      n_ev = 2; ev_cyc[0] = 0; ev_dat[0] = 8'($urandom); ev_cyc[1] = FRAME; ev_dat[1] = 8'h81;
      run_scenario("stopend", 90, -1);

      n_ev = 3; ev_cyc[0] = 0; ev_dat[0] = 8'($urandom);
      ev_cyc[1] = 3;     ev_dat[1] = 8'($urandom);
      ev_cyc[2] = FRAME; ev_dat[2] = 8'($urandom);
      run_scenario("stopend_held", 135, -1);

      for (int r = 0; r < 6; r++) begin
         n_ev = 5;
         t    = 0;
         for (int k = 0; k < n_ev; k++) begin
            ev_cyc[k] = t;
            ev_dat[k] = 8'($urandom);
            t = t + int'($urandom_range(1, 30));
         end
         run_scenario("random", ev_cyc[n_ev - 1] + n_ev * FRAME + 5, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmitter stage directly downstream of the CPU-to-TX data filter. It consumes the filter's one-cycle TxEn strobe and the TxData byte, and serialises each byte as an 8N1 frame on TxSerial. A one-byte holding register absorbs a byte that arrives mid-frame, so two consecutive bytes from a 16-bit CPU word go out back-to-back without a gap.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range >= 2; counter width = $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
TxEn  input  1  one-cycle strobe; TxData valid when high
TxData  input  8  byte to transmit
TxSerial  output  1  serial line; idles high
TxBusy  output  1  high while a frame is in progress
TxDone  output  1  one-cycle pulse at the end of each frame
TxOverrun  output  1  one-cycle pulse when a strobed byte is dropped

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low. On a clk edge with reset=0: TxSerial=1, TxBusy=0, TxDone=0, TxOverrun=0, state=IDLE, holding register empty, counters cleared.
- Reset mid-frame aborts the frame: TxSerial=1 from the next cycle, any held byte is discarded, and no TxDone is issued.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: TxSerial=1, TxBusy=0. If TxEn is high at an edge, latch TxData into the shift register and go to START.
- START: TxSerial=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send 8 bits LSB first, each bit for CLKS_PER_BIT cycles. A 3-bit index counts 0..7, then go to STOP.
- STOP: TxSerial=1 for CLKS_PER_BIT cycles.
- At the last STOP cycle, the next state is chosen as follows:
  - Holding register full: load the held byte and go to START, with no idle cycle.
  - Holding register empty and TxEn high that cycle: load TxData and go to START.
  - Otherwise: go to IDLE.
- TxDone: pulses high for exactly the one cycle following the last STOP cycle, whichever next state was taken.
- Latency: TxEn sampled at edge 0 gives START on cycles 1..CLKS_PER_BIT. Total frame length is 10*CLKS_PER_BIT cycles.
- TxBusy: high from the first START cycle through the last STOP cycle. It stays high continuously across back-to-back frames and is low during the TxDone cycle only when the FSM returns to IDLE.
- TxEn while not IDLE (excluding the STOP-end case above):
  - Holding register empty: capture TxData into it.
  - Holding register full: drop the byte and pulse TxOverrun for one cycle.
- TxEn at STOP end with the holding register full: the held byte starts and the incoming byte enters the holding register, which is freed the same edge. No overrun.
- TxData is sampled only on edges where TxEn=1; it is ignored otherwise.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset and idle (CLKS_PER_BIT=4): assert reset for 3 cycles, release, idle 20 cycles -> TxSerial=1, TxBusy=0, TxDone=0, TxOverrun=0 throughout.
2. Single frame 0xA5 with TxEn at edge 0 -> TxSerial sequence in 4-cycle blocks starting at cycle 1 is 0 | 1,0,1,0,0,1,0,1 | 1. TxBusy is high on cycles 1..40; TxDone pulses on cycle 41.
3. Back-to-back: TxEn with 0x3C at edge 0, then TxEn with 0xC3 at cycle 10 -> frames are contiguous (second START on cycles 41..44). TxBusy stays high on cycles 1..80; TxDone pulses on cycles 41 and 81; no overrun.
4. Overrun: TxEn with 0x11 at 0, 0x22 at 6, 0x33 at 12 -> TxOverrun pulses once (cycle 13). Only 0x11 and 0x22 are transmitted.
5. Reset mid-frame: start 0xFF, hold 0x55, assert reset during DATA bit 3 -> TxSerial=1 the next cycle, no TxDone, 0x55 never sent. A subsequent 0x00 frame is bit-exact.
6. STOP-end coincidence: TxEn with 0x81 on the last STOP cycle of a prior frame, holding register empty -> the next frame starts with no idle cycle, TxDone pulses once for the prior frame, and 0x81 is sent correctly.
